// File: rtl/el2_pkg.sv
// -----------------------------------------------------------------------------
// el2_pkg (slice)
// Shared EL2 core package. Only the PMP access-type packet used by the PMP
// check-channel arbiter is reproduced here; the type is owned by el2_pkg and
// is reused unchanged by every PMP client.
//   el2_pmp_type_pkt_t : READ / WRITE / EXEC access kind presented to the PMP.
// -----------------------------------------------------------------------------
package el2_pkg;

   typedef enum logic [1:0] {
      READ  = 2'b00,
      WRITE = 2'b01,
      EXEC  = 2'b10
   } el2_pmp_type_pkt_t;

endpackage

// File: rtl/el2_pmp_chan_arb_pkg.sv
// -----------------------------------------------------------------------------
// el2_pmp_chan_arb_pkg
// Constants and helpers for the PMP check-channel arbiter. No new types live
// here; the access-type packet comes from el2_pkg.
//   PMP_CHAN_IDLE_ADDR / PMP_CHAN_IDLE_TYPE : channel values while S1 is empty.
//   rr_wrap()                               : single-step modulo for indices
//                                             known to be below 2*nreq.
// -----------------------------------------------------------------------------
package el2_pmp_chan_arb_pkg;
   import el2_pkg::*;

   localparam logic [31:0]       PMP_CHAN_IDLE_ADDR = 32'h0000_0000;
   localparam el2_pmp_type_pkt_t PMP_CHAN_IDLE_TYPE = READ;

   function automatic int unsigned rr_wrap(input int unsigned idx,
                                           input int unsigned nreq);
      return (idx >= nreq) ? (idx - nreq) : idx;
   endfunction

endpackage

// File: rtl/el2_pmp_arb_sel.sv
// -----------------------------------------------------------------------------
// el2_pmp_arb_sel
// One-hot grant selection for the PMP check channel. The search starts at
// 'ptr' and wraps; with ptr tied to zero this degenerates to fixed priority
// with index 0 highest.
// Ports:
//   valid [NREQ] : request vector
//   ptr   [IDW]  : first index searched (must be < NREQ)
//   en           : grant enable (low forces gnt to zero)
//   gnt   [NREQ] : one-hot grant, subset of valid
// -----------------------------------------------------------------------------
module el2_pmp_arb_sel #(
   parameter int unsigned NREQ = 3,
   parameter int unsigned IDW  = $clog2(NREQ)
) (
   input  logic [NREQ-1:0] valid,
   input  logic [IDW-1:0]  ptr,
   input  logic            en,
   output logic [NREQ-1:0] gnt
);

   logic found;

   // Two ordered passes (indices >= ptr, then indices < ptr) realise the
   // wrapped search with constant bit indices only.
   always_comb begin
      gnt   = '0;
      found = 1'b0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         if (en && !found && valid[i] && (i >= 32'(ptr))) begin
            gnt[i] = 1'b1;
            found  = 1'b1;
         end
      end
      for (int unsigned i = 0; i < NREQ; i++) begin
         if (en && !found && valid[i] && (i < 32'(ptr))) begin
            gnt[i] = 1'b1;
            found  = 1'b1;
         end
      end
   end

endmodule

// File: rtl/el2_pmp_chan_arb.sv
// -----------------------------------------------------------------------------
// el2_pmp_chan_arb
// Shares one combinational PMP check channel between NREQ requesters.
// Three-stage pipeline: handshake (N) -> S1 drives the channel (N+1) ->
// S2 returns the registered verdict (N+2). One request per cycle, responses
// in grant order, never back-pressured.
// Configuration macro:
//   RV_PMP_ARB_RR_EN : defined   -> round-robin (pointer = last grant + 1)
//                      undefined -> fixed priority, index 0 highest
// Ports:
//   clk, rst_l       : clock, asynchronous active-low reset
//   scan_mode        : pass-through only, no functional effect
//   cfg_busy         : PMP CSR write in progress, blocks new grants
//   req_valid/addr/type [NREQ] : per-requester check request
//   req_ready [NREQ] : one-hot grant (accept = req_valid & req_ready)
//   pmp_chan_addr/type : request presented to the PMP (0/READ when idle)
//   pmp_chan_err     : combinational PMP verdict for the channel request
//   rsp_valid [NREQ] : one-cycle one-hot response strobe
//   rsp_err          : access fault for the responding requester
// -----------------------------------------------------------------------------
module el2_pmp_chan_arb
   import el2_pkg::*;
   import el2_pmp_chan_arb_pkg::*;
#(
   parameter int unsigned NREQ = 3,
   parameter int unsigned IDW  = $clog2(NREQ)
) (
   input  logic                clk,
   input  logic                rst_l,
   input  logic                scan_mode,
   input  logic                cfg_busy,
   input  logic [NREQ-1:0]     req_valid,
   input  logic [31:0]         req_addr [NREQ],
   input  el2_pmp_type_pkt_t   req_type [NREQ],
   output logic [NREQ-1:0]     req_ready,
   output logic [31:0]         pmp_chan_addr,
   output el2_pmp_type_pkt_t   pmp_chan_type,
   input  logic                pmp_chan_err,
   output logic [NREQ-1:0]     rsp_valid,
   output logic                rsp_err
);

   logic                unused_scan_mode;
   logic                sel_en;
   logic [IDW-1:0]      rr_ptr;
   logic [NREQ-1:0]     gnt;
   logic [IDW-1:0]      gnt_idx;
   logic [31:0]         gnt_addr;
   el2_pmp_type_pkt_t   gnt_type;

   logic                s1_valid;
   logic [IDW-1:0]      s1_idx;
   logic [31:0]         s1_addr;
   el2_pmp_type_pkt_t   s1_type;

   logic                s2_valid;
   logic [IDW-1:0]      s2_idx;
   logic                s2_err;

   assign unused_scan_mode = scan_mode;

   // rst_l in the enable keeps req_ready low for the whole reset window,
   // while still allowing a grant on the first edge after release.
   assign sel_en = rst_l & ~cfg_busy;

   el2_pmp_arb_sel #(
      .NREQ (NREQ),
      .IDW  (IDW)
   ) u_sel (
      .valid (req_valid),
      .ptr   (rr_ptr),
      .en    (sel_en),
      .gnt   (gnt)
   );

   assign req_ready = gnt;

   always_comb begin
      gnt_idx  = '0;
      gnt_addr = '0;
      gnt_type = READ;
      for (int unsigned i = 0; i < NREQ; i++) begin
         if (gnt[i]) begin
            gnt_idx  = IDW'(i);
            gnt_addr = req_addr[i];
            gnt_type = req_type[i];
         end
      end
   end

`ifdef RV_PMP_ARB_RR_EN
   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         rr_ptr <= '0;
      end else if (|gnt) begin
         rr_ptr <= IDW'(rr_wrap(32'(gnt_idx) + 32'd1, NREQ));
      end
   end
`else
   assign rr_ptr = '0;
`endif

   // S1: request captured at the handshake; later changes on req_* are ignored.
   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         s1_valid <= 1'b0;
         s1_idx   <= '0;
         s1_addr  <= '0;
         s1_type  <= READ;
      end else begin
         s1_valid <= |gnt;
         if (|gnt) begin
            s1_idx  <= gnt_idx;
            s1_addr <= gnt_addr;
            s1_type <= gnt_type;
         end
      end
   end

   assign pmp_chan_addr = s1_valid ? s1_addr : PMP_CHAN_IDLE_ADDR;
   assign pmp_chan_type = s1_valid ? s1_type : PMP_CHAN_IDLE_TYPE;

   // S2: verdict sampled with the PMP configuration seen during the S1 cycle.
   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         s2_valid <= 1'b0;
         s2_idx   <= '0;
         s2_err   <= 1'b0;
      end else begin
         s2_valid <= s1_valid;
         s2_idx   <= s1_idx;
         s2_err   <= s1_valid & pmp_chan_err;
      end
   end

   always_comb begin
      rsp_valid = '0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         rsp_valid[i] = s2_valid && (s2_idx == IDW'(i));
      end
   end

   assign rsp_err = s2_valid & s2_err;

endmodule

// File: tb/tb_el2_pmp_chan_arb.sv
// -----------------------------------------------------------------------------
// tb_el2_pmp_chan_arb
// Bench for el2_pmp_chan_arb (NREQ=3). A simple PMP stub answers the channel.
// The reference keeps a queue of granted transactions stamped with their grant
// cycle: the channel must show the entry granted one cycle earlier and the
// response must be the entry granted two cycles earlier. Honors
// RV_PMP_ARB_RR_EN to choose the expected arbitration rule.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_el2_pmp_chan_arb;
   import el2_pkg::*;

   localparam int N = 3;

   logic              clk       = 1'b0;
   logic              rst_l     = 1'b1;
   logic              scan_mode = 1'b0;
   logic              cfg_busy  = 1'b0;
   logic [N-1:0]      req_valid = '0;
   logic [31:0]       req_addr [N];
   el2_pmp_type_pkt_t req_type [N];
   logic [N-1:0]      req_ready;
   logic [31:0]       pmp_chan_addr;
   el2_pmp_type_pkt_t pmp_chan_type;
   logic              pmp_chan_err;
   logic [N-1:0]      rsp_valid;
   logic              rsp_err;

   bit r1_x = 1'b1;          // execute permission of the low region (changes under cfg_busy)
   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;
   int rr_ptr  = 0;

   typedef struct {
      int                idx;
      logic [31:0]       addr;
      el2_pmp_type_pkt_t typ;
      int                gcyc;
      bit                err;
   } ent_t;
   ent_t q[$];

   always #5 clk = ~clk;

   el2_pmp_chan_arb #(
      .NREQ (N)
   ) dut (
      .clk           (clk),
      .rst_l         (rst_l),
      .scan_mode     (scan_mode),
      .cfg_busy      (cfg_busy),
      .req_valid     (req_valid),
      .req_addr      (req_addr),
      .req_type      (req_type),
      .req_ready     (req_ready),
      .pmp_chan_addr (pmp_chan_addr),
      .pmp_chan_type (pmp_chan_type),
      .pmp_chan_err  (pmp_chan_err),
      .rsp_valid     (rsp_valid),
      .rsp_err       (rsp_err)
   );

   // PMP regions: 0x8000_xxxx R/W no X; 0x0000_xxxx R, X per r1_x; else no access.
   function automatic bit pmp_fault(input logic [31:0] a, input el2_pmp_type_pkt_t t,
                                    input bit x1);
      if (a[31:16] == 16'h8000) return (t == EXEC);
      if (a[31:16] == 16'h0000) return (t == WRITE) || ((t == EXEC) && !x1);
      return 1'b1;
   endfunction

   always_comb pmp_chan_err = pmp_fault(pmp_chan_addr, pmp_chan_type, r1_x);

   function automatic int model_grant();
      if (!rst_l || cfg_busy) return -1;
`ifdef RV_PMP_ARB_RR_EN
      for (int k = 0; k < N; k++)
         if (req_valid[(rr_ptr + k) % N]) return (rr_ptr + k) % N;
`else
      for (int k = 0; k < N; k++)
         if (req_valid[k]) return k;
`endif
      return -1;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
      end
   endtask

   task automatic set_rst(input logic v);
      rst_l = v;
      if (!v) begin
         q.delete();
         rr_ptr = 0;
      end
   endtask

   task automatic rand_req(input int i);
      logic [15:0] lo;
      lo = 16'($urandom);
      case ($urandom_range(0, 2))
         0:       req_addr[i] = {16'h8000, lo};
         1:       req_addr[i] = {16'h0000, lo};
         default: req_addr[i] = {16'h4000, lo};
      endcase
      req_type[i] = el2_pmp_type_pkt_t'(2'($urandom_range(0, 2)));
   endtask

   // One clock: check outputs mid-cycle against the model, then commit the grant.
   task automatic cycle();
      int                g;
      int                s1;
      int                s2;
      logic [31:0]       e_addr;
      el2_pmp_type_pkt_t e_type;
      logic [N-1:0]      e_rv;
      logic              e_err;
      ent_t              e;
      @(negedge clk);
      #1;
      g  = model_grant();
      s1 = -1;
      s2 = -1;
      foreach (q[i]) begin
         if (q[i].gcyc == cyc - 1) s1 = i;
         if (q[i].gcyc == cyc - 2) s2 = i;
      end
      e_addr = 32'h0;
      e_type = READ;
      e_rv   = '0;
      e_err  = 1'b0;
      if (s1 >= 0) begin
         q[s1].err = pmp_fault(q[s1].addr, q[s1].typ, r1_x);
         e_addr    = q[s1].addr;
         e_type    = q[s1].typ;
      end
      if (s2 >= 0) begin
         e_rv[q[s2].idx] = 1'b1;
         e_err           = q[s2].err;
      end
      chk("req_ready", 32'(req_ready), (g >= 0) ? (32'd1 << g) : 32'd0);
      chk("chan_addr", pmp_chan_addr, e_addr);
      chk("chan_type", 32'(pmp_chan_type), 32'(e_type));
      chk("rsp_valid", 32'(rsp_valid), 32'(e_rv));
      chk("rsp_err",   32'(rsp_err), 32'(e_err));
      @(posedge clk);
      if (g >= 0) begin
         e.idx  = g;
         e.addr = req_addr[g];
         e.typ  = req_type[g];
         e.gcyc = cyc;
         e.err  = 1'b0;
         q.push_back(e);
         rr_ptr = (g + 1) % N;
      end
      while (q.size() > 0 && q[0].gcyc <= cyc - 2) q.delete(0);
      cyc++;
      #1;
   endtask

   initial begin
      for (int i = 0; i < N; i++) begin
         req_addr[i] = 32'h0;
         req_type[i] = READ;
      end

      // Reset with all requesters pending: everything must stay at zero.
      #2;
      set_rst(1'b0);
      req_valid = '1;
      repeat (2) cycle();

      // Release; first grant on the first edge after release, all three contending.
      set_rst(1'b1);
      repeat (6) begin
         for (int i = 0; i < N; i++) rand_req(i);
         cycle();
      end
      req_valid = '0;
      repeat (2) cycle();

      // Single READ to an R=1 region.
      req_addr[0]  = 32'h8000_0000;
      req_type[0]  = READ;
      req_valid    = 3'b001;
      cycle();
      req_valid    = '0;
      repeat (3) cycle();

      // Requesters 0 and 2 contend, then 0 drops.
      req_addr[0] = 32'h8000_0100; req_type[0] = WRITE;
      req_addr[2] = 32'h0000_0200; req_type[2] = READ;
      req_valid   = 3'b101;
      repeat (3) cycle();
      req_valid   = 3'b100;
      cycle();
      req_valid   = '0;
      repeat (2) cycle();

      // cfg_busy window: entry granted just before completes with the config
      // of its S1 cycle (X revoked), no grants during the window.
      req_addr[1] = 32'h0000_1000;
      req_type[1] = EXEC;
      req_valid   = 3'b010;
      cycle();
      cfg_busy    = 1'b1;
      r1_x        = 1'b0;
      repeat (4) cycle();
      cfg_busy    = 1'b0;
      r1_x        = 1'b1;
      cycle();
      req_valid   = '0;
      repeat (2) cycle();

      // Fault then clean back-to-back; address changes after handshake.
      req_addr[2] = 32'h8000_0010; req_type[2] = EXEC;
      req_valid   = 3'b100;
      cycle();
      req_addr[2] = 32'h8000_0020; req_type[2] = READ;
      cycle();
      req_valid   = '0;
      repeat (2) cycle();

      // Randomized traffic.
      repeat (300) begin
         req_valid = N'($urandom);
         cfg_busy  = ($urandom_range(0, 7) == 0);
         if ($urandom_range(0, 15) == 0) r1_x = ~r1_x;
         for (int i = 0; i < N; i++) rand_req(i);
         cycle();
      end
      cfg_busy  = 1'b0;
      r1_x      = 1'b1;
      req_valid = '0;
      repeat (2) cycle();

      // Reset right after a grant: the grant never responds.
      req_addr[0] = 32'h8000_0040; req_type[0] = READ;
      req_valid   = 3'b001;
      cycle();
      set_rst(1'b0);
      req_valid   = '1;
      repeat (3) cycle();
      set_rst(1'b1);
      req_valid   = 3'b010;
      req_addr[1] = 32'h0000_0040; req_type[1] = READ;
      cycle();
      req_valid   = '0;
      repeat (3) cycle();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
